vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; successor to our fixed 640x480 controller.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/vga_axis_counter.sv | 79 +++++++
 rtl/vga_timing_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA raster timing generator:
//     - default timing constants for 640x480@60 and 800x600@60
//     - axis_region_e : which part of a line/frame an axis counter is in
//     - total()       : sum of the four segments of one axis
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   // 640x480 @ 60 Hz (25.175 MHz pixel clock)
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;

   // 800x600 @ 60 Hz (40 MHz pixel clock, positive syncs)
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;

   // Segments of one axis, in counting order.
   typedef enum logic [1:0] {
      REG_ACTIVE = 2'd0,
      REG_FP     = 2'd1,
      REG_SYNC   = 2'd2,
      REG_BP     = 2'd3
   } axis_region_e;

   // Number of counts in one full line (or frame, in lines).
   function automatic int total(input int active, input int fp,
                                input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One dimension of the raster: a modulo-TOTAL counter plus decode of the
//   current count into active / sync regions.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (counter -> 0)
//   en          - advance the counter on this clock edge
//   cnt         - current count, 0..TOTAL-1
//   wrap        - count is TOTAL-1 (next enabled edge returns to 0)
//   active      - count lies in the visible segment
//   sync_on     - count lies in the sync segment (polarity applied by caller)
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE  = 640,
   parameter int FP      = 16,
   parameter int SYNC    = 96,
   parameter int BP      = 48,
   parameter int COORD_W = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   output logic [COORD_W-1:0] cnt,
   output logic               wrap,
   output logic               active,
   output logic               sync_on
);

   localparam int TOTAL = total(ACTIVE, FP, SYNC, BP);

   localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

   // Segment boundaries are kept one bit wider than the counter so that an
   // end boundary equal to 2**COORD_W does not wrap to zero.
   localparam logic [COORD_W:0] ACTIVE_END = (COORD_W+1)'(ACTIVE);
   localparam logic [COORD_W:0] FP_END     = (COORD_W+1)'(ACTIVE + FP);
   localparam logic [COORD_W:0] SYNC_END   = (COORD_W+1)'(ACTIVE + FP + SYNC);

   logic [COORD_W-1:0] cnt_q;
   logic [COORD_W-1:0] cnt_d;
   logic [COORD_W:0]   cnt_x;
   axis_region_e       region;

   assign cnt_x = {1'b0, cnt_q};
   assign wrap  = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      region = REG_BP;
      if (cnt_x < ACTIVE_END) begin
         region = REG_ACTIVE;
      end else if (cnt_x < FP_END) begin
         region = REG_FP;
      end else if (cnt_x < SYNC_END) begin
         region = REG_SYNC;
      end
   end

   assign cnt     = cnt_q;
   assign active  = (region == REG_ACTIVE);
   assign sync_on = (region == REG_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator with pixel clock-enable,
//   programmable sync polarity, line/frame strobes and a look-ahead fetch
//   address that leads the displayed position by LOOKAHEAD pixel counts.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   pix_en          - pixel strobe; timing advances only on edges with pix_en=1
//   h_sync, v_sync  - sync outputs, asserted level H_POL / V_POL
//   display_enable  - registered position is visible
//   column, row     - visible coordinate, 0 while blanked
//   line_start      - one-clock pulse when registered h position is 0
//   frame_start     - one-clock pulse when registered position is (0,0)
//   fetch_valid     - look-ahead position is visible
//   fetch_column/row- look-ahead coordinate, 0 when fetch_valid=0
// All outputs are registered: an enabled edge captures the decode of the
// current counter position, then the counters advance (latency 1 clock).
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE  = VGA640_H_ACTIVE,
   parameter int H_FP      = VGA640_H_FP,
   parameter int H_SYNC    = VGA640_H_SYNC,
   parameter int H_BP      = VGA640_H_BP,
   parameter bit H_POL     = 1'b0,
   parameter int V_ACTIVE  = VGA640_V_ACTIVE,
   parameter int V_FP      = VGA640_V_FP,
   parameter int V_SYNC    = VGA640_V_SYNC,
   parameter int V_BP      = VGA640_V_BP,
   parameter bit V_POL     = 1'b0,
   parameter int COORD_W   = 11,
   parameter int LOOKAHEAD = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   output logic               h_sync,
   output logic               v_sync,
   output logic               display_enable,
   output logic [COORD_W-1:0] column,
   output logic [COORD_W-1:0] row,
   output logic               line_start,
   output logic               frame_start,
   output logic               fetch_valid,
   output logic [COORD_W-1:0] fetch_column,
   output logic [COORD_W-1:0] fetch_row
);

   localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam longint MAX_COUNTS = longint'(1) << COORD_W;

   // Parameter sanity: counters must hold a full line/frame and the fetch
   // address may lead by at most the horizontal blanking minus one.
   generate
      if (longint'(H_TOTAL) > MAX_COUNTS) begin : g_h_total_too_big
         $error("vga_timing_gen: H_TOTAL exceeds 2**COORD_W");
      end
      if (longint'(V_TOTAL) > MAX_COUNTS) begin : g_v_total_too_big
         $error("vga_timing_gen: V_TOTAL exceeds 2**COORD_W");
      end
      if (LOOKAHEAD < 0 || LOOKAHEAD > H_FP + H_SYNC + H_BP - 1) begin : g_lookahead_range
         $error("vga_timing_gen: LOOKAHEAD outside 0..H_FP+H_SYNC+H_BP-1");
      end
   endgenerate

   localparam logic [COORD_W:0] H_TOTAL_X   = (COORD_W+1)'(H_TOTAL);
   localparam logic [COORD_W:0] H_ACTIVE_X  = (COORD_W+1)'(H_ACTIVE);
   localparam logic [COORD_W:0] V_ACTIVE_X  = (COORD_W+1)'(V_ACTIVE);
   localparam logic [COORD_W:0] LOOKAHEAD_X = (COORD_W+1)'(LOOKAHEAD);

   // ------------------------------------------------------------------ axes
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_active;
   logic               v_active;
   logic               h_sync_on;
   logic               v_sync_on;
   logic               v_en;

   // The vertical counter steps once per line, on the edge where H wraps.
   assign v_en = pix_en & h_wrap;

   vga_axis_counter #(
      .ACTIVE  (H_ACTIVE),
      .FP      (H_FP),
      .SYNC    (H_SYNC),
      .BP      (H_BP),
      .COORD_W (COORD_W)
   ) u_h_axis (
      .clk     (clk),
      .reset   (reset),
      .en      (pix_en),
      .cnt     (h_cnt),
      .wrap    (h_wrap),
      .active  (h_active),
      .sync_on (h_sync_on)
   );

   vga_axis_counter #(
      .ACTIVE  (V_ACTIVE),
      .FP      (V_FP),
      .SYNC    (V_SYNC),
      .BP      (V_BP),
      .COORD_W (COORD_W)
   ) u_v_axis (
      .clk     (clk),
      .reset   (reset),
      .en      (v_en),
      .cnt     (v_cnt),
      .wrap    (v_wrap),
      .active  (v_active),
      .sync_on (v_sync_on)
   );

   // ------------------------------------------------------------ look-ahead
   // fh never exceeds 2*H_TOTAL-2, so one extra bit is enough; a single
   // conditional subtract folds it back into the line and carries into v.
   logic [COORD_W:0]   fh_sum;
   logic [COORD_W:0]   fh;
   logic [COORD_W-1:0] fv;
   logic               f_visible;

   always_comb begin
      fh_sum = {1'b0, h_cnt} + LOOKAHEAD_X;
      fh     = fh_sum;
      fv     = v_cnt;
      if (fh_sum >= H_TOTAL_X) begin
         fh = fh_sum - H_TOTAL_X;
         fv = v_wrap ? '0 : v_cnt + 1'b1;
      end
      f_visible = (fh < H_ACTIVE_X) && ({1'b0, fv} < V_ACTIVE_X);
   end

   // ------------------------------------------------------ output registers
   logic               h_sync_q,         h_sync_d;
   logic               v_sync_q,         v_sync_d;
   logic               display_enable_q, display_enable_d;
   logic [COORD_W-1:0] column_q,         column_d;
   logic [COORD_W-1:0] row_q,            row_d;
   logic               line_start_q,     line_start_d;
   logic               frame_start_q,    frame_start_d;
   logic               fetch_valid_q,    fetch_valid_d;
   logic [COORD_W-1:0] fetch_column_q,   fetch_column_d;
   logic [COORD_W-1:0] fetch_row_q,      fetch_row_d;
   logic               visible;

   assign visible = h_active & v_active;

   always_comb begin
      // Level outputs hold between pixel strobes; strobes last one clock.
      h_sync_d         = h_sync_q;
      v_sync_d         = v_sync_q;
      display_enable_d = display_enable_q;
      column_d         = column_q;
      row_d            = row_q;
      fetch_valid_d    = fetch_valid_q;
      fetch_column_d   = fetch_column_q;
      fetch_row_d      = fetch_row_q;
      line_start_d     = 1'b0;
      frame_start_d    = 1'b0;

      if (pix_en) begin
         h_sync_d         = h_sync_on ? H_POL : ~H_POL;
         v_sync_d         = v_sync_on ? V_POL : ~V_POL;
         display_enable_d = visible;
         column_d         = visible ? h_cnt : '0;
         row_d            = visible ? v_cnt : '0;
         fetch_valid_d    = f_visible;
         fetch_column_d   = f_visible ? fh[COORD_W-1:0] : '0;
         fetch_row_d      = f_visible ? fv : '0;
         line_start_d     = (h_cnt == '0);
         frame_start_d    = (h_cnt == '0) && (v_cnt == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_sync_q         <= ~H_POL;
         v_sync_q         <= ~V_POL;
         display_enable_q <= 1'b0;
         column_q         <= '0;
         row_q            <= '0;
         line_start_q     <= 1'b0;
         frame_start_q    <= 1'b0;
         fetch_valid_q    <= 1'b0;
         fetch_column_q   <= '0;
         fetch_row_q      <= '0;
      end else begin
         h_sync_q         <= h_sync_d;
         v_sync_q         <= v_sync_d;
         display_enable_q <= display_enable_d;
         column_q         <= column_d;
         row_q            <= row_d;
         line_start_q     <= line_start_d;
         frame_start_q    <= frame_start_d;
         fetch_valid_q    <= fetch_valid_d;
         fetch_column_q   <= fetch_column_d;
         fetch_row_q      <= fetch_row_d;
      end
   end

   assign h_sync         = h_sync_q;
   assign v_sync         = v_sync_q;
   assign display_enable = display_enable_q;
   assign column         = column_q;
   assign row            = row_q;
   assign line_start     = line_start_q;
   assign frame_start    = frame_start_q;
   assign fetch_valid    = fetch_valid_q;
   assign fetch_column   = fetch_column_q;
   assign fetch_row      = fetch_row_q;

endmodule
